cdb_arbiter: RTL and testbench

//  Shares N_BUS result broadcast buses among N_REQ functional-unit result ports (ALU lanes, CMP,
//  CMP_br, ld/st address ALU). Each requester has a DEPTH-entry result FIFO; every cycle up to N_BUS
//  non-empty FIFO heads are granted round-robin and broadcast to the ROB and reservation stations.
//  FU results are never dropped while req_ready is high, so FUs stay purely combinational.

---
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-port and broadcast-bus bundle of the CDB arbiter.
// slave = arbiter side, master = FU/ROB side.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int N_BUS  = 2,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ROB_W-1:0]  req_rob;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_ready;
  logic [N_BUS-1:0]        bus_valid;
  logic [N_BUS*ROB_W-1:0]  bus_rob;
  logic [N_BUS*DATA_W-1:0] bus_value;

  modport slave (
    input  req_valid, req_rob, req_value,
    output req_ready, bus_valid, bus_rob, bus_value
  );

  modport master (
    output req_valid, req_rob, req_value,
    input  req_ready, bus_valid, bus_rob, bus_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: per-FU result FIFOs onto N_BUS broadcast buses.
// Define CDB_BYPASS_EN to let results on an empty FIFO broadcast same cycle.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_BUS  = 2,
  parameter int DEPTH  = 2,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  cdb_arbiter_if.slave cdb
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RW  = $clog2(N_REQ);
  localparam int NBW = $clog2(N_BUS + 1);

  logic [ROB_W-1:0]  rob_q [N_REQ][DEPTH];
  logic [DATA_W-1:0] val_q [N_REQ][DEPTH];
  logic [PW-1:0]     wp_q  [N_REQ];
  logic [PW-1:0]     rp_q  [N_REQ];
  logic [CW-1:0]     cnt_q [N_REQ];
  logic [RW-1:0]     rr_q, rr_d;

  logic [N_REQ-1:0] ready, gnt, enq, deq;
  logic [RW-1:0]    last, idx;
  logic [RW:0]      sum;
  logic [NBW-1:0]   nb;
  logic             cand;
  logic [ROB_W-1:0] crob;
  logic [DATA_W-1:0] cval;
  logic [N_BUS-1:0]        bv;
  logic [N_BUS*ROB_W-1:0]  brob;
  logic [N_BUS*DATA_W-1:0] bval;

  always_comb begin
    ready = '0;
    for (int i = 0; i < N_REQ; i++)
      ready[i] = cnt_q[i] < CW'(DEPTH);
  end

  // Walk requesters from rr_q; the k-th hit lands on bus k.
  always_comb begin
    gnt  = '0;
    nb   = '0;
    last = rr_q;
    bv   = '0;
    brob = '0;
    bval = '0;
    sum  = '0;
    idx  = '0;
    cand = 1'b0;
    crob = '0;
    cval = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_q} + (RW+1)'(k);
      if (sum >= (RW+1)'(N_REQ))
        sum = sum - (RW+1)'(N_REQ);
      idx  = sum[RW-1:0];
      cand = cnt_q[idx] != '0;
      crob = rob_q[idx][rp_q[idx]];
      cval = val_q[idx][rp_q[idx]];
`ifdef CDB_BYPASS_EN
      if (cnt_q[idx] == '0 && cdb.req_valid[idx]) begin
        cand = 1'b1;
        crob = cdb.req_rob[idx*ROB_W +: ROB_W];
        cval = cdb.req_value[idx*DATA_W +: DATA_W];
      end
`endif
      if (cand && !flush && nb < NBW'(N_BUS)) begin
        gnt[idx] = 1'b1;
        last     = idx;
        for (int j = 0; j < N_BUS; j++) begin
          if (nb == NBW'(j)) begin
            bv[j] = 1'b1;
            brob[j*ROB_W +: ROB_W]   = crob;
            bval[j*DATA_W +: DATA_W] = cval;
          end
        end
        nb = nb + NBW'(1);
      end
    end
  end

  always_comb begin
    enq = '0;
    deq = '0;
    for (int i = 0; i < N_REQ; i++) begin
      deq[i] = gnt[i] && cnt_q[i] != '0;
      // A granted result on an empty FIFO was bypassed, not stored.
      enq[i] = cdb.req_valid[i] && ready[i] && !flush
            && !(gnt[i] && cnt_q[i] == '0);
    end
    rr_d = rr_q;
    if (gnt != '0)
      rr_d = (last == RW'(N_REQ-1)) ? '0 : last + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (flush) begin
      rr_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < N_REQ; i++) begin
        if (enq[i]) wp_q[i] <= wp_q[i] + PW'(1);
        if (deq[i]) rp_q[i] <= rp_q[i] + PW'(1);
        if (enq[i] && !deq[i]) cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (!enq[i] && deq[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (enq[i]) begin
        rob_q[i][wp_q[i]] <= cdb.req_rob[i*ROB_W +: ROB_W];
        val_q[i][wp_q[i]] <= cdb.req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb.req_ready = ready;
  assign cdb.bus_valid = bv;
  assign cdb.bus_rob   = brob;
  assign cdb.bus_value = bval;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter, default (non-bypass) build.
// Inputs change at negedge, outputs sampled 1ns later.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int checks = 0;
  int fails = 0;
  logic [73:0] obs;
  logic [73:0] exp;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(4), .N_BUS(2), .ROB_W(4), .DATA_W(32)) cif();

  cdb_arbiter #(
    .N_REQ(4), .N_BUS(2), .DEPTH(2), .ROB_W(4), .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .cdb(cif)
  );

  assign obs = {cif.bus_valid, cif.bus_rob, cif.bus_value};

  task automatic drive(input logic [3:0] v, input logic [15:0] r,
                       input logic [127:0] d, input logic f);
    @(negedge clk);
    cif.req_valid = v;
    cif.req_rob   = r;
    cif.req_value = d;
    flush = f;
    #1;
  endtask

  task automatic idle();
    drive(4'h0, 16'h0, 128'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cif.req_valid = '0;
    cif.req_rob = '0;
    cif.req_value = '0;
    flush = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    cif.req_valid = '0;
    cif.req_rob = '0;
    cif.req_value = '0;
    #3;
    checks++;
    if (cif.req_ready !== 4'hF) begin
      fails++;
      $display("FAIL rst_ready got=%h exp=%h", cif.req_ready, 4'hF);
    end
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL rst_bus got=%h exp=%h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(4'hF, 16'h3210, {32'h3, 32'h2, 32'h1, 32'h0}, 1'b0);
    idle();
    exp = {2'b11, 8'h10, 32'h1, 32'h0};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL rst_pre got=%h exp=%h", obs, exp);
    end
    #2;
    rst = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL rst_mid_bus got=%h exp=%h", obs, exp);
    end
    checks++;
    if (cif.req_ready !== 4'hF) begin
      fails++;
      $display("FAIL rst_mid_ready got=%h exp=%h", cif.req_ready, 4'hF);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL rst_after got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0001, 16'h0003, 128'h11, 1'b0);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL single_t got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b01, 8'h03, 32'h0, 32'h11};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL single_t1 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL single_drain got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive(4'hF, 16'h3210, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL cont_c0 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b11, 8'h10, 32'hA1, 32'hA0};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL cont_c1 got=%h exp=%h", obs, exp);
    end
    drive(4'b1001, 16'h5006, {32'h55, 32'h0, 32'h0, 32'h66}, 1'b0);
    exp = {2'b11, 8'h32, 32'hA3, 32'hA2};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL cont_c2 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b11, 8'h56, 32'h55, 32'h66};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL cont_rr_wrap got=%h exp=%h", obs, exp);
    end
    idle();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL cont_drain got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(4'b0111, 16'h0210, {32'h0, 32'h300, 32'h200, 32'h100}, 1'b0);
    checks++;
    if (cif.req_ready !== 4'hF) begin
      fails++;
      $display("FAIL bp_rdy0 got=%h exp=%h", cif.req_ready, 4'hF);
    end
    drive(4'b0111, 16'h0210, {32'h0, 32'h301, 32'h201, 32'h101}, 1'b0);
    exp = {2'b11, 8'h10, 32'h200, 32'h100};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_c1 got=%h exp=%h", obs, exp);
    end
    drive(4'b0011, 16'h0010, {32'h0, 32'h0, 32'h202, 32'h102}, 1'b0);
    checks++;
    if (cif.req_ready !== 4'b1011) begin
      fails++;
      $display("FAIL bp_full got=%h exp=%h", cif.req_ready, 4'b1011);
    end
    exp = {2'b11, 8'h02, 32'h101, 32'h300};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_c2 got=%h exp=%h", obs, exp);
    end
    drive(4'b0100, 16'h0200, {32'h0, 32'h302, 32'h0, 32'h0}, 1'b0);
    checks++;
    if (cif.req_ready !== 4'b1101) begin
      fails++;
      $display("FAIL bp_rdy3 got=%h exp=%h", cif.req_ready, 4'b1101);
    end
    exp = {2'b11, 8'h21, 32'h301, 32'h201};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_c3 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b11, 8'h10, 32'h202, 32'h102};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_c4 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b01, 8'h02, 32'h0, 32'h302};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_c5 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL bp_drain got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b0001, 16'h000E, 128'hE0, 1'b0);
    drive(4'b0111, 16'h0210, {32'h0, 32'h32, 32'h31, 32'h30}, 1'b0);
    exp = {2'b01, 8'h0E, 32'h0, 32'hE0};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fl_pre got=%h exp=%h", obs, exp);
    end
    drive(4'b1000, 16'h3000, {32'h33, 32'h0, 32'h0, 32'h0}, 1'b1);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fl_bus got=%h exp=%h", obs, exp);
    end
    drive(4'b1001, 16'h5006, {32'h55, 32'h0, 32'h0, 32'h66}, 1'b0);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fl_empty got=%h exp=%h", obs, exp);
    end
    checks++;
    if (cif.req_ready !== 4'hF) begin
      fails++;
      $display("FAIL fl_ready got=%h exp=%h", cif.req_ready, 4'hF);
    end
    idle();
    exp = {2'b11, 8'h56, 32'h55, 32'h66};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fl_rr got=%h exp=%h", obs, exp);
    end
    idle();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fl_drain got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    drive(4'b0001, 16'h0000, 128'h400, 1'b0);
    drive(4'b1001, 16'h7000, {32'h777, 32'h0, 32'h0, 32'h401}, 1'b0);
    exp = {2'b01, 8'h00, 32'h0, 32'h400};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fair_c1 got=%h exp=%h", obs, exp);
    end
    drive(4'b0001, 16'h0000, 128'h402, 1'b0);
    exp = {2'b11, 8'h07, 32'h401, 32'h777};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fair_req3 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = {2'b01, 8'h00, 32'h0, 32'h402};
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fair_c3 got=%h exp=%h", obs, exp);
    end
    idle();
    exp = '0;
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL fair_drain got=%h exp=%h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
